// File: rtl/riscv_div_seq_pkg.sv
// Shared decode patterns and types for the M-extension divide sequencer.
package riscv_div_seq_pkg;

  localparam int unsigned DEC_W = 15;

  // {funct7, funct3, opcode[6:2]}
  localparam logic [DEC_W-1:0] DEC_DIV   = 15'b0000001_100_01100;
  localparam logic [DEC_W-1:0] DEC_DIVU  = 15'b0000001_101_01100;
  localparam logic [DEC_W-1:0] DEC_REM   = 15'b0000001_110_01100;
  localparam logic [DEC_W-1:0] DEC_REMU  = 15'b0000001_111_01100;
  localparam logic [DEC_W-1:0] DEC_DIVW  = 15'b0000001_100_01110;
  localparam logic [DEC_W-1:0] DEC_DIVUW = 15'b0000001_101_01110;
  localparam logic [DEC_W-1:0] DEC_REMW  = 15'b0000001_110_01110;
  localparam logic [DEC_W-1:0] DEC_REMUW = 15'b0000001_111_01110;

  typedef enum logic [2:0] {
    IDLE,
    CHK,
    BUSY,
    CORR,
    DONE
  } div_state_t;

  typedef struct packed {
    logic sgn;
    logic rem;
    logic word;
  } div_op_t;

endpackage

// File: rtl/riscv_div_iter.sv
// Radix-2 restoring divider datapath: {rem,quot} shift register with trial subtract.
module riscv_div_iter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] quot_init,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem,
  output logic [W-1:0] quot
);

  logic [W-1:0] div_q;
  logic [W:0]   shifted;
  logic [W:0]   diff;

  assign shifted = {rem, quot[W-1]};
  assign diff    = shifted - {1'b0, div_q};

  // Negative trial difference (bit W set) restores the shifted remainder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quot  <= '0;
      div_q <= '0;
    end else if (load) begin
      rem   <= '0;
      quot  <= quot_init;
      div_q <= divisor;
    end else if (step) begin
      if (!diff[W]) begin
        rem  <= diff[W-1:0];
        quot <= {quot[W-2:0], 1'b1};
      end else begin
        rem  <= shifted[W-1:0];
        quot <= {quot[W-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/riscv_div_seq.sv
// Multi-cycle DIV/DIVU/REM/REMU(+W) sequencer with special-case filter and sign correction.
module riscv_div_seq
  import riscv_div_seq_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          HAS_RVW = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] opa,
  input  logic [XLEN-1:0] opb,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(XLEN);
  localparam bit          W_EN  = HAS_RVW && (XLEN == 64);
  localparam logic [31:0] MIN32 = 32'h8000_0000;

  div_state_t state, state_n;
  div_op_t    op_q, dec_op;
  logic       dec_hit;
  logic [DEC_W-1:0] key;

  logic [XLEN-1:0] a_q, b_q, a_w, b_w, a_ext, min_w;
  logic [XLEN-1:0] mag_a, mag_b, quot_init, spec_res;
  logic [XLEN-1:0] q_raw, r_raw, res_sel, corr_res, res_n;
  logic [XLEN-1:0] it_rem, it_quot;
  logic            a_neg, b_neg, div_zero, ovf, special;
  logic [CNT_W-1:0] cnt_q;
  logic            q_neg_q, r_neg_q;
  logic            latch, load, step;

  logic unused_instr;
  assign unused_instr = ^{instr[24:15], instr[11:7], instr[1:0]};

  assign key = {instr[31:25], instr[14:12], instr[6:2]};

  // Instruction decode; W forms only when enabled for a 64-bit core.
  always_comb begin
    dec_hit = 1'b0;
    dec_op  = '0;
    case (key)
      DEC_DIV:   begin dec_hit = 1'b1; dec_op = '{sgn: 1'b1, rem: 1'b0, word: 1'b0}; end
      DEC_DIVU:  begin dec_hit = 1'b1; dec_op = '{sgn: 1'b0, rem: 1'b0, word: 1'b0}; end
      DEC_REM:   begin dec_hit = 1'b1; dec_op = '{sgn: 1'b1, rem: 1'b1, word: 1'b0}; end
      DEC_REMU:  begin dec_hit = 1'b1; dec_op = '{sgn: 1'b0, rem: 1'b1, word: 1'b0}; end
      DEC_DIVW:  begin dec_hit = W_EN; dec_op = '{sgn: 1'b1, rem: 1'b0, word: 1'b1}; end
      DEC_DIVUW: begin dec_hit = W_EN; dec_op = '{sgn: 1'b0, rem: 1'b0, word: 1'b1}; end
      DEC_REMW:  begin dec_hit = W_EN; dec_op = '{sgn: 1'b1, rem: 1'b1, word: 1'b1}; end
      DEC_REMUW: begin dec_hit = W_EN; dec_op = '{sgn: 1'b0, rem: 1'b1, word: 1'b1}; end
      default:   ;
    endcase
  end

  // Operands narrowed to the effective width (sign- or zero-extended for W forms).
  always_comb begin
    a_w   = a_q;
    b_w   = b_q;
    a_ext = a_q;
    min_w = {1'b1, {(XLEN-1){1'b0}}};
    if (op_q.word) begin
      a_ext = XLEN'($signed(a_q[31:0]));
      min_w = XLEN'($signed(MIN32));
      if (op_q.sgn) begin
        a_w = XLEN'($signed(a_q[31:0]));
        b_w = XLEN'($signed(b_q[31:0]));
      end else begin
        a_w = XLEN'(a_q[31:0]);
        b_w = XLEN'(b_q[31:0]);
      end
    end
  end

  assign a_neg    = op_q.sgn & a_w[XLEN-1];
  assign b_neg    = op_q.sgn & b_w[XLEN-1];
  assign mag_a    = a_neg ? -a_w : a_w;
  assign mag_b    = b_neg ? -b_w : b_w;
  assign div_zero = (b_w == '0);
  assign ovf      = op_q.sgn && (a_w == min_w) && (b_w == '1);
  assign special  = div_zero || ovf;

  // W forms park the 32-bit dividend in the upper half so 32 steps suffice.
  assign quot_init = op_q.word ? (mag_a << (XLEN - 32)) : mag_a;

  always_comb begin
    spec_res = '0;
    if (div_zero) begin
      spec_res = op_q.rem ? a_ext : '1;
    end else if (!op_q.rem) begin
      spec_res = min_w;
    end
  end

  assign q_raw    = q_neg_q ? -it_quot : it_quot;
  assign r_raw    = r_neg_q ? -it_rem  : it_rem;
  assign res_sel  = op_q.rem ? r_raw : q_raw;
  assign corr_res = op_q.word ? XLEN'($signed(res_sel[31:0])) : res_sel;
  assign res_n    = (state == CHK) ? spec_res : corr_res;

  assign in_ready = (state == IDLE) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    latch   = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && dec_hit) begin
          latch   = 1'b1;
          state_n = CHK;
        end
      end
      CHK: begin
        if (special) begin
          state_n = DONE;
        end else begin
          load    = 1'b1;
          state_n = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt_q == '0) state_n = CORR;
      end
      CORR:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) begin
      state_n = IDLE;
      latch   = 1'b0;
      load    = 1'b0;
      step    = 1'b0;
    end
  end

  // Operand latch, step counter, sign flags and the registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      out_valid <= (state_n == DONE);
      if (latch) begin
        op_q <= dec_op;
        a_q  <= opa;
        b_q  <= opb;
      end
      if (load) begin
        cnt_q   <= op_q.word ? CNT_W'(31) : CNT_W'(XLEN - 1);
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
      end else if (step) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (state_n == DONE && state != DONE) result <= res_n;
    end
  end

  riscv_div_iter #(.W(XLEN)) u_iter (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .step      (step),
    .quot_init (quot_init),
    .divisor   (mag_b),
    .rem       (it_rem),
    .quot      (it_quot)
  );

endmodule

// File: tb/tb_riscv_div_seq.sv
// Directed self-checking bench for riscv_div_seq (32-bit core plus a 64-bit RVW core).
module tb_riscv_div_seq;

  localparam logic [31:0] I_DIV   = 32'h0200_4033;
  localparam logic [31:0] I_DIVU  = 32'h0200_5033;
  localparam logic [31:0] I_REM   = 32'h0200_6033;
  localparam logic [31:0] I_REMU  = 32'h0200_7033;
  localparam logic [31:0] I_MUL   = 32'h0200_0033;
  localparam logic [31:0] I_DIVW  = 32'h0200_403B;
  localparam logic [31:0] I_DIVUW = 32'h0200_503B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] instr = '0, opa = '0, opb = '0, result;

  logic        flush64 = 1'b0, in_valid64 = 1'b0, out_ready64 = 1'b0;
  logic        in_ready64, out_valid64;
  logic [31:0] instr64 = '0;
  logic [63:0] opa64 = '0, opb64 = '0, result64;

  int total = 0;
  int passed = 0;

  riscv_div_seq #(.XLEN(32), .HAS_RVW(1'b0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .opa(opa), .opb(opb), .out_valid(out_valid),
    .out_ready(out_ready), .result(result)
  );

  riscv_div_seq #(.XLEN(64), .HAS_RVW(1'b1)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .opa(opa64), .opb(opb64), .out_valid(out_valid64),
    .out_ready(out_ready64), .result(result64)
  );

  // Present a request for one cycle; returns #1 after the accepting edge (cycle 1).
  task automatic start_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1; instr = ins; opa = a; opb = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat, output logic [31:0] res);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic start_op64(input logic [31:0] ins, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    in_valid64 = 1'b1; instr64 = ins; opa64 = a; opb64 = b;
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  task automatic wait_result64(output int lat, output logic [63:0] res);
    lat = 1;
    while (out_valid64 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result64;
  endtask

  task automatic retire64();
    out_ready64 = 1'b1;
    @(posedge clk); #1;
    out_ready64 = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got %h want 0", result); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else passed++;
    total++; if (result64 !== 64'h0) $display("FAIL reset_result64 got %h want 0", result64); else passed++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_signed();
    int lat;
    logic [31:0] res;
    start_op(I_DIV, 32'd20, 32'hFFFF_FFFD);
    wait_result(lat, res);
    total++; if (lat != 35) $display("FAIL div_latency got %0d want 35", lat); else passed++;
    total++; if (res !== 32'hFFFF_FFFA) $display("FAIL div_20_m3 got %h want fffffffa", res); else passed++;
    retire();
    start_op(I_REM, 32'd20, 32'hFFFF_FFFD);
    wait_result(lat, res);
    total++; if (lat != 35) $display("FAIL rem_latency got %0d want 35", lat); else passed++;
    total++; if (res !== 32'h0000_0002) $display("FAIL rem_20_m3 got %h want 00000002", res); else passed++;
    retire();
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] res;
    start_op(I_DIVU, 32'h1234_5678, 32'h0);
    wait_result(lat, res);
    total++; if (lat != 2) $display("FAIL divu_zero_latency got %0d want 2", lat); else passed++;
    total++; if (res !== 32'hFFFF_FFFF) $display("FAIL divu_zero got %h want ffffffff", res); else passed++;
    retire();
    start_op(I_REMU, 32'h1234_5678, 32'h0);
    wait_result(lat, res);
    total++; if (lat != 2) $display("FAIL remu_zero_latency got %0d want 2", lat); else passed++;
    total++; if (res !== 32'h1234_5678) $display("FAIL remu_zero got %h want 12345678", res); else passed++;
    retire();
  endtask

  task automatic test_overflow();
    int lat;
    logic [31:0] res;
    start_op(I_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(lat, res);
    total++; if (lat != 2) $display("FAIL div_ovf_latency got %0d want 2", lat); else passed++;
    total++; if (res !== 32'h8000_0000) $display("FAIL div_ovf got %h want 80000000", res); else passed++;
    retire();
    start_op(I_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_result(lat, res);
    total++; if (lat != 2) $display("FAIL rem_ovf_latency got %0d want 2", lat); else passed++;
    total++; if (res !== 32'h0) $display("FAIL rem_ovf got %h want 00000000", res); else passed++;
    retire();
  endtask

  task automatic test_illegal();
    bit seen = 1'b0;
    start_op(I_MUL, 32'd6, 32'd7);
    start_op(I_DIVW, 32'd6, 32'd2);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL illegal_dropped got out_valid=1 want 0"); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL illegal_in_ready got %b want 1", in_ready); else passed++;
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] res;
    bit bp_ok = 1'b1;
    bit seen = 1'b0;
    start_op(I_DIVU, 32'd1000, 32'd9);
    wait_result(lat, res);
    total++; if (res !== 32'd111) $display("FAIL bp_result got %h want 0000006f", res); else passed++;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || result !== 32'd111 || in_ready !== 1'b0) bp_ok = 1'b0;
    end
    total++; if (!bp_ok) $display("FAIL bp_hold got valid=%b result=%h in_ready=%b want 1/0000006f/0", out_valid, result, in_ready); else passed++;
    out_ready = 1'b1;
    in_valid = 1'b1; instr = I_DIVU; opa = 32'd100; opb = 32'd7;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_no_overlap got in_ready=%b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL bp_retire_valid got %b want 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_retire_in_ready got %b want 1", in_ready); else passed++;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL bp_overlap_dropped got out_valid=1 want 0"); else passed++;
  endtask

  task automatic test_flush();
    int lat;
    logic [31:0] res;
    bit seen = 1'b0;
    start_op(I_DIV, 32'd20, 32'hFFFF_FFFD);
    repeat (11) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    repeat (50) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL flush_busy got out_valid=1 want 0"); else passed++;
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; instr = I_DIVU; opa = 32'd9; opb = 32'd3;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b want 0", in_ready); else passed++;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL flush_accept got out_valid=1 want 0"); else passed++;
    start_op(I_DIVU, 32'd100, 32'd7);
    wait_result(lat, res);
    total++; if (lat != 35) $display("FAIL flush_next_latency got %0d want 35", lat); else passed++;
    total++; if (res !== 32'h0000_000E) $display("FAIL flush_next_divu got %h want 0000000e", res); else passed++;
    retire();
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    start_op(I_DIV, 32'd20, 32'hFFFF_FFFD);
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_valid got %b want 0", out_valid); else passed++;
    total++; if (result !== 32'h0) $display("FAIL rst_mid_result got %h want 0", result); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (45) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    total++; if (seen) $display("FAIL rst_mid_no_result got out_valid=1 want 0"); else passed++;
  endtask

  task automatic test_word64();
    int lat;
    logic [63:0] res;
    start_op64(I_DIVW, 64'h0000_0000_FFFF_FFF8, 64'd2);
    wait_result64(lat, res);
    total++; if (lat != 35) $display("FAIL divw_latency got %0d want 35", lat); else passed++;
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL divw got %h want fffffffffffffffc", res); else passed++;
    retire64();
    start_op64(I_DIVUW, 64'h0000_0000_FFFF_FFF8, 64'd2);
    wait_result64(lat, res);
    total++; if (res !== 64'h0000_0000_7FFF_FFFC) $display("FAIL divuw got %h want 000000007ffffffc", res); else passed++;
    retire64();
    start_op64(I_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    wait_result64(lat, res);
    total++; if (lat != 67) $display("FAIL div64_latency got %0d want 67", lat); else passed++;
    total++; if (res !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL div64 got %h want fffffffffffffffd", res); else passed++;
    retire64();
  endtask

  initial begin
    test_reset();
    test_signed();
    test_div_zero();
    test_overflow();
    test_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_word64();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
